// File: rtl/fetch_redirect.sv
// fetch_redirect -- instruction fetch front end with branch redirect.
//
// Issues one instruction-memory request at a time, delivers the returned
// word into the IF/ID register, and buffers one extra entry in a skid
// register when ID is stalled. A taken branch from EX flushes younger
// stages, redirects the PC, and discards the data of any request that was
// already outstanding when the branch arrived.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   branch_enable/target     EX-stage redirect (already qualified)
//   stall                    hold IF/ID outputs
//   inst_req/addr            instruction-memory request (addr held until ack)
//   inst_ack/data            request completion and returned word
//   if_valid/pc/inst         IF/ID register
//   flush_if_id/flush_id_ex  same-cycle kill pulses (mirror branch_enable)
//   redirect_cnt             taken-redirect counter
//
// Build option: define FETCH_REDIRECT_CNT_EN to implement redirect_cnt;
// otherwise it is tied to zero and no counter register exists.
module fetch_redirect #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_enable,
    input  logic [31:0] branch_target,
    input  logic        stall,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [31:0] redirect_cnt
);

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] req_addr, req_addr_nxt;
    logic        kill, kill_nxt;
    logic        skid_valid;
    logic [31:0] skid_pc, skid_inst;
    logic        deliver, to_if, to_skid;

    assign inst_req    = (state == REQ);
    assign inst_addr   = req_addr;
    assign flush_if_id = branch_enable;
    assign flush_id_ex = branch_enable;

    // A returned word is kept only if it was not requested down a path a
    // branch has since abandoned (kill) or is abandoning this cycle.
    assign deliver = (state == REQ) && inst_ack && !kill && !branch_enable;
    assign to_if   = deliver && (!stall || !if_valid);
    assign to_skid = deliver && stall && if_valid;

    always_comb begin
        state_nxt    = state;
        req_addr_nxt = req_addr;
        kill_nxt     = kill;
        pc_nxt       = pc;
        if (branch_enable)
            pc_nxt = branch_target;
        else if (deliver)
            pc_nxt = req_addr + 32'd4;
        case (state)
            IDLE: begin
                if (!skid_valid && !branch_enable) begin
                    state_nxt    = REQ;
                    req_addr_nxt = pc;
                end
            end
            REQ: begin
                if (inst_ack) begin
                    kill_nxt = 1'b0;
                    // Back-to-back only while the skid stays empty; a skid
                    // fill, a kill or a branch parks the FSM in IDLE.
                    if (to_if) begin
                        state_nxt    = REQ;
                        req_addr_nxt = req_addr + 32'd4;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (branch_enable) begin
                    kill_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            req_addr <= RESET_PC;
            kill     <= 1'b0;
        end else begin
            state    <= state_nxt;
            req_addr <= req_addr_nxt;
            kill     <= kill_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            if_valid   <= 1'b0;
            if_pc      <= 32'd0;
            if_inst    <= 32'd0;
            skid_valid <= 1'b0;
            skid_pc    <= 32'd0;
            skid_inst  <= 32'd0;
        end else begin
            pc <= pc_nxt;
            if (branch_enable) begin
                if_valid   <= 1'b0;
                skid_valid <= 1'b0;
            end else if (to_if) begin
                if_valid <= 1'b1;
                if_pc    <= req_addr;
                if_inst  <= inst_data;
            end else if (to_skid) begin
                skid_valid <= 1'b1;
                skid_pc    <= req_addr;
                skid_inst  <= inst_data;
            end else if (!stall) begin
                // ID consumed the current entry; refill from skid if any.
                if_valid   <= skid_valid;
                skid_valid <= 1'b0;
                if (skid_valid) begin
                    if_pc   <= skid_pc;
                    if_inst <= skid_inst;
                end
            end
        end
    end

`ifdef FETCH_REDIRECT_CNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= 32'd0;
        else if (branch_enable)
            cnt_q <= cnt_q + 32'd1;
    end

    assign redirect_cnt = cnt_q;
`else
    assign redirect_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_redirect.sv
// Bench for fetch_redirect: directed stimulus, a transaction-level model of
// the fetch front end (outstanding request + a FIFO of IF/ID then skid
// entries), and hand-computed literal checks at key points.
module tb_fetch_redirect;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        be = 1'b0;
    logic [31:0] bt = 32'd0;
    logic        stall = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] data = 32'd0;
    logic        inst_req, if_valid, flush_if_id, flush_id_ex;
    logic [31:0] inst_addr, if_pc, if_inst, redirect_cnt;

    always #5 clk = ~clk;

    fetch_redirect #(.RESET_PC(32'h1c000000)) dut (
        .clk(clk), .rst(rst),
        .branch_enable(be), .branch_target(bt), .stall(stall),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_ack(ack), .inst_data(data),
        .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .redirect_cnt(redirect_cnt)
    );

    int n_vec = 0;
    int n_err = 0;
    logic last_flush;

    // Model state.
    bit          m_init = 0;
    bit          m_out, m_kill;
    logic [31:0] m_pc, m_addr, m_cnt;
    logic [31:0] q_pc[$];
    logic [31:0] q_inst[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        logic [31:0] exp_cnt;
`ifdef FETCH_REDIRECT_CNT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 32'd0;
`endif
        last_flush = flush_if_id;
        if (m_init) begin
            chk("inst_req", {31'd0, inst_req}, {31'd0, m_out});
            if (m_out) chk("inst_addr", inst_addr, m_addr);
            chk("if_valid", {31'd0, if_valid}, (q_pc.size() > 0) ? 32'd1 : 32'd0);
            if (q_pc.size() > 0) begin
                chk("if_pc", if_pc, q_pc[0]);
                chk("if_inst", if_inst, q_inst[0]);
            end
            chk("flush_if_id", {31'd0, flush_if_id}, {31'd0, be});
            chk("flush_id_ex", {31'd0, flush_id_ex}, {31'd0, be});
            chk("redirect_cnt", redirect_cnt, exp_cnt);
        end
    endtask

    task automatic model_step();
        int          sz0;
        bit          dlv;
        logic [31:0] pc0;
        if (rst) begin
            m_init = 1;
            m_pc   = 32'h1c000000;
            m_addr = 32'h1c000000;
            m_out  = 0;
            m_kill = 0;
            m_cnt  = 32'd0;
            q_pc.delete();
            q_inst.delete();
            return;
        end
        sz0 = q_pc.size();
        pc0 = m_pc;
        dlv = m_out && ack && !m_kill && !be;
        if (be) begin
            q_pc.delete();
            q_inst.delete();
            m_cnt = m_cnt + 32'd1;
        end else begin
            if (!stall && sz0 > 0) begin
                void'(q_pc.pop_front());
                void'(q_inst.pop_front());
            end
            if (dlv) begin
                q_pc.push_back(m_addr);
                q_inst.push_back(data);
            end
        end
        if (be) m_pc = bt;
        else if (dlv) m_pc = m_addr + 32'd4;
        if (!m_out) begin
            // New request only with no branch and no pending second entry.
            if (!be && sz0 <= 1) begin
                m_out  = 1;
                m_addr = pc0;
            end
        end else if (ack) begin
            m_kill = 0;
            if (dlv && q_pc.size() <= 1) m_addr = m_addr + 32'd4;
            else m_out = 0;
        end else if (be) begin
            m_kill = 1;
        end
    endtask

    // One clock: drive, check at the falling edge, advance model at rise.
    task automatic cyc(input bit r, input bit b, input logic [31:0] t,
                       input bit s, input bit a);
        rst = r; be = b; bt = t; stall = s; ack = a; data = $urandom;
        @(negedge clk);
        compare_model();
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        // Reset state.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst_req", {31'd0, inst_req}, 32'd0);
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_cnt", redirect_cnt, 32'd0);

        // Sequential fetch; an ack while IDLE is ignored.
        cyc(0, 0, 0, 0, 1);
        chk("idle_ack_ignored", {31'd0, if_valid}, 32'd0);
        chk("addr0", inst_addr, 32'h1c000000);
        cyc(0, 0, 0, 0, 1);
        chk("seq_if_pc0", if_pc, 32'h1c000000);
        chk("addr1", inst_addr, 32'h1c000004);
        cyc(0, 0, 0, 0, 1);
        chk("seq_if_pc1", if_pc, 32'h1c000004);
        chk("addr2", inst_addr, 32'h1c000008);
        cyc(0, 0, 0, 0, 1);
        chk("seq_if_pc2", if_pc, 32'h1c000008);

        // Stall with skid fill and drain.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 1);
        chk("stall_hold_pc", if_pc, 32'h1c000000);
        chk("stall_req_off", {31'd0, inst_req}, 32'd0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        chk("stall_hold_pc3", if_pc, 32'h1c000000);
        cyc(0, 0, 0, 0, 0);
        chk("skid_drain_pc", if_pc, 32'h1c000004);
        chk("drain_req_off", {31'd0, inst_req}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("after_drain_addr", inst_addr, 32'h1c000008);
        chk("after_drain_ifv", {31'd0, if_valid}, 32'd0);

        // Branch while 1c000008 outstanding, ack two cycles later.
        cyc(0, 1, 32'h1c000100, 0, 0);
        chk("br_flush", {31'd0, last_flush}, 32'd1);
        chk("br_addr_held", inst_addr, 32'h1c000008);
        cyc(0, 0, 0, 0, 0);
        chk("br_flush_1cyc", {31'd0, last_flush}, 32'd0);
        cyc(0, 0, 0, 0, 1);
        chk("killed_ifv", {31'd0, if_valid}, 32'd0);
        chk("killed_req", {31'd0, inst_req}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("br_target_addr", inst_addr, 32'h1c000100);

        // Branch coinciding with ack; then wrap at 2^32.
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 32'hfffffffc, 0, 1);
        chk("coinc_ifv", {31'd0, if_valid}, 32'd0);
        chk("coinc_req", {31'd0, inst_req}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("coinc_target", inst_addr, 32'hfffffffc);
        cyc(0, 0, 0, 0, 1);
        chk("wrap_if_pc", if_pc, 32'hfffffffc);
        chk("wrap_addr", inst_addr, 32'h00000000);
        cyc(0, 0, 0, 0, 1);

        // Reset mid-request; following ack ignored.
        cyc(1, 0, 0, 0, 0);
        chk("midrst_req", {31'd0, inst_req}, 32'd0);
        cyc(0, 0, 0, 0, 1);
        chk("midrst_ack_ignored", {31'd0, if_valid}, 32'd0);
        chk("midrst_restart", inst_addr, 32'h1c000000);
        chk("midrst_cnt", redirect_cnt, 32'd0);
        cyc(0, 0, 0, 0, 1);

        // Branch overrides stall, issued from IDLE with a full skid.
        cyc(0, 0, 0, 1, 1);
        cyc(0, 1, 32'h1c000040, 1, 0);
        chk("br_over_stall", {31'd0, if_valid}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("br_idle_target", inst_addr, 32'h1c000040);

        // Pseudo-random soak checked by the model.
        for (int i = 0; i < 300; i++)
            cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
                {$urandom_range(0, 255), 2'b00} + 32'h1c000000,
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
